uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Transmit-side controller that shares one serial UART line between two byte requesters.
- Round-robin arbitration picks the next requester; the block then sequences the frame bit-by-bit: start, data LSB-first, optional parity, 1 or 2 stop bits.
- Frame format uses the same encoding as the Framer configuration: data length 7/8, parity 00/11 none, 01 odd, 10 even, and stop select.
- Sits between the host-side byte sources and the TX pin.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit (>=2).

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- tx_en  input  1  transmit enable; low = abort and idle line.
- data_len  input  1  0 = 7-bit data, 1 = 8-bit data.
- parity  input  2  00/11 none, 01 odd, 10 even.
- stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
- req0_valid  input  1  requester 0 has a byte.
- req0_data  input  8  requester 0 byte.
- req0_ready  output  1  handshake accept for requester 0.
- req1_valid  input  1  requester 1 has a byte.
- req1_data  input  8  requester 1 byte.
- req1_ready  output  1  handshake accept for requester 1.
- txd  output  1  serial line; idle high.
- busy  output  1  frame in progress.
- grant_id  output  1  requester whose frame is in flight (valid while busy).
- done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset: state IDLE; txd=1; busy=0; done=0; reqX_ready=0; grant_id=0; last_grant=1, so requester 0 wins the first tie.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE, ready outputs (combinational):
  - When tx_en=1 and at least one valid is high, assert ready to exactly one requester.
  - Only one valid high: grant that requester.
  - Both valid high: grant the requester that is not last_grant.
  - Handshake cycle T = valid&ready. In cycle T the block latches the byte, data_len, parity and stop_bits, and updates last_grant and grant_id.
  - Configuration changes after T do not affect the frame in flight.
- Timing:
  - START begins at T+1.
  - Each bit drives txd for exactly CLKS_PER_BIT cycles, counted by the baud counter, which is reloaded on every bit transition.
  - Frame bit count N = 1 + (7|8) + (parity∈{01,10} ? 1 : 0) + (1|2); N ranges from 9 to 12.
  - Bits occupy cycles T+1 .. T+N*CLKS_PER_BIT.
- Per-state txd:
  - START: txd=0.
  - DATA: shift out byte[0] first; 7-bit mode sends byte[6:0] and ignores bit 7.
  - PARITY: even → XOR of sent data bits; odd → inverted XOR of sent data bits.
  - STOP: txd=1 for 1 or 2 bit times.
- Completion:
  - At T+N*CLKS_PER_BIT+1 the FSM is in IDLE and done=1 for one cycle.
  - ready may assert in that same cycle, giving back-to-back frames with no extra idle bit.
- busy = 1 in every non-IDLE state.
- tx_en=0:
  - Any state goes to IDLE on the next edge; txd=1; the in-flight frame is dropped with no done pulse.
  - ready is held 0 while tx_en=0.
  - last_grant is retained.
- rst mid-frame: identical to the reset values above; the frame is lost.
- reqX_valid deasserting while not ready: no effect; no byte is accepted.

Decomposition:
- Package uart_pkg:
  - parity codes PAR_NONE0=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10, PAR_NONE3=2'b11.
  - tx_state_t enum.
  - function frame_bits(data_len, parity, stop_bits) returning 4 bits.
- One sub-module baud_gen: down-counter with a reload input, emitting a bit_end pulse every CLKS_PER_BIT cycles.

Test Plan (CLKS_PER_BIT=4):
- Single frame, 8-bit even parity:
  - Stimulus: req0 sends 0xAB, data_len=1, parity=10, stop=0.
  - Response: txd bit sequence 0,1,1,0,1,0,1,0,1,1(parity),1; each bit held 4 cycles; done at T+45.
- 7-bit odd parity, 2 stop bits:
  - Stimulus: 0x2B, data_len=0, parity=01, stop=1.
  - Response: bits 0,1,1,0,1,0,1,0,1(parity),1,1; N=11.
- No parity, all-ones data:
  - Stimulus: 0xFF, data_len=0, parity=11, stop=1.
  - Response: N=10; bits 0,1×7,1,1; busy high for 40 cycles.
- Arbitration:
  - Stimulus: req0 and req1 both valid continuously, bytes 0x00 and 0xFF.
  - Response: grants go 0,1,0,1; frames back-to-back; done pulses spaced exactly N*4+1 cycles apart.
- Abort:
  - Stimulus: drop tx_en during the DATA state of a frame.
  - Response: txd=1 on the next cycle; busy=0; no done pulse; ready stays 0 until tx_en=1.
  - Follow-up: the next accepted frame comes from the other requester.
- Reset mid-frame:
  - Stimulus: assert rst during STOP.
  - Response: all outputs return to reset values on the next edge; the next simultaneous request grants req0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the two-requester UART transmit scheduler.
// Parity codes match the Framer configuration encoding.
package uart_pkg;

    localparam logic [1:0] PAR_NONE0 = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NONE3 = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    function automatic logic parity_enabled(input logic [1:0] parity);
        parity_enabled = 1'b0;
        case (parity)
            PAR_ODD, PAR_EVEN:    parity_enabled = 1'b1;
            PAR_NONE0, PAR_NONE3: parity_enabled = 1'b0;
        endcase
    endfunction

    // Total serial bits in one frame: start + data + optional parity + stop.
    function automatic logic [3:0] frame_bits(input logic       data_len,
                                              input logic [1:0] parity,
                                              input logic       stop_bits);
        frame_bits = 4'd1
                   + (data_len ? 4'd8 : 4'd7)
                   + (parity_enabled(parity) ? 4'd1 : 4'd0)
                   + (stop_bits ? 4'd2 : 4'd1);
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_baud_gen.sv
// Bit-period down-counter: bit_end pulses on the last cycle of every bit,
// reload restarts a full bit period on the next cycle.
module baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || reload || count == '0) begin
            count <= LOAD;
        end else begin
            count <= count - 1'b1;
        end
    end

    assign bit_end = (count == '0);

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin shares one UART TX line between two byte requesters and
// serialises the accepted byte as start, data LSB-first, parity, stop.
module uart_tx_scheduler #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       data_len,
    input  logic [1:0] parity,
    input  logic       stop_bits,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       txd,
    output logic       busy,
    output logic       grant_id,
    output logic       done
);
    import uart_pkg::*;

    tx_state_t  state;
    tx_state_t  state_next;

    logic [7:0] shift_q;
    logic       len_q;
    logic       par_en_q;
    logic       par_bit_q;
    logic [3:0] bits_left_q;
    logic [2:0] data_cnt_q;
    logic       last_grant_q;
    logic       grant_id_q;
    logic       done_q;

    logic       bit_end;
    logic       baud_reload;
    logic       any_valid;
    logic       pick;
    logic       can_accept;
    logic       handshake;
    logic       data_last;
    logic       frame_end;
    logic [7:0] sel_byte;
    logic       data_xor;

    // Reload in IDLE so the first bit after a handshake is a full period.
    assign baud_reload = (state == IDLE) || bit_end;

    baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .reload (baud_reload),
        .bit_end(bit_end)
    );

    // On a tie the requester that did not win last time gets the line.
    assign any_valid  = req0_valid || req1_valid;
    assign pick       = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign can_accept = (state == IDLE) && tx_en && !rst;
    assign req0_ready = can_accept && any_valid && !pick;
    assign req1_ready = can_accept && any_valid && pick;
    assign handshake  = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign sel_byte  = pick ? req1_data : req0_data;
    assign data_xor  = data_len ? ^sel_byte : ^sel_byte[6:0];
    assign data_last = (data_cnt_q == (len_q ? 3'd7 : 3'd6));
    assign frame_end = (state == STOP) && bit_end && (bits_left_q == 4'd1) && tx_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= frame_end;
        end
    end

    always_comb begin
        state_next = state;
        txd        = 1'b1;
        busy       = (state != IDLE);
        if (!tx_en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (handshake) state_next = START;
                START:   if (bit_end) state_next = DATA;
                DATA:    if (bit_end && data_last) state_next = par_en_q ? PARITY : STOP;
                PARITY:  if (bit_end) state_next = STOP;
                STOP:    if (bit_end && bits_left_q == 4'd1) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
        case (state)
            START:   txd = 1'b0;
            DATA:    txd = shift_q[0];
            PARITY:  txd = par_bit_q;
            default: txd = 1'b1;
        endcase
    end

    // Byte and framing options are captured at the handshake so later
    // configuration changes cannot disturb the frame on the wire.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q      <= 8'h00;
            len_q        <= 1'b0;
            par_en_q     <= 1'b0;
            par_bit_q    <= 1'b0;
            bits_left_q  <= 4'd0;
            data_cnt_q   <= 3'd0;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
        end else if (handshake) begin
            shift_q      <= sel_byte;
            len_q        <= data_len;
            par_en_q     <= parity_enabled(parity);
            par_bit_q    <= (parity == PAR_EVEN) ? data_xor : ~data_xor;
            bits_left_q  <= frame_bits(data_len, parity, stop_bits);
            data_cnt_q   <= 3'd0;
            last_grant_q <= pick;
            grant_id_q   <= pick;
        end else if (bit_end && state != IDLE) begin
            bits_left_q <= bits_left_q - 1'b1;
            if (state == DATA) begin
                shift_q    <= {1'b0, shift_q[7:1]};
                data_cnt_q <= data_cnt_q + 1'b1;
            end
        end
    end

    assign grant_id = grant_id_q;
    assign done     = done_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed and randomized bench for uart_tx_scheduler against a frame-level
// model that expands each accepted byte into its list of line bits.
module tb_uart_tx_scheduler;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en;
    logic       data_len;
    logic [1:0] parity;
    logic       stop_bits;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       txd;
    logic       busy;
    logic       grant_id;
    logic       done;

    int total = 0;
    int bad   = 0;

    bit m_in_frame = 1'b0;
    int m_pos      = 0;
    bit m_bits[$];
    bit m_done     = 1'b0;
    bit m_last     = 1'b1;
    bit m_grant    = 1'b0;
    int m_hs_cycle = 0;

    int   cycle    = 0;
    int   busy_cnt = 0;
    logic prev_busy = 1'b0;
    logic txd_log[$];
    logic grant_log[$];
    int   done_log[$];
    int   t0;
    int   got;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .CLKS_PER_BIT(C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_en     (tx_en),
        .data_len  (data_len),
        .parity    (parity),
        .stop_bits (stop_bits),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .txd       (txd),
        .busy      (busy),
        .grant_id  (grant_id),
        .done      (done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [7:0] d0,
                                 input logic v1, input logic [7:0] d1,
                                 input logic en, input logic len,
                                 input logic [1:0] par, input logic st);
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        tx_en      = en;
        data_len   = len;
        parity     = par;
        stop_bits  = st;
    endtask

    function automatic void buildFrame(input logic [7:0] b, input logic len8,
                                       input logic [1:0] par, input logic st2);
        int n;
        int ones;
        n    = len8 ? 8 : 7;
        ones = 0;
        m_bits.delete();
        m_bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            m_bits.push_back(b[i]);
            ones += int'(b[i]);
        end
        if (par == 2'b10) m_bits.push_back(bit'(ones % 2));
        if (par == 2'b01) m_bits.push_back(bit'(1 - ones % 2));
        m_bits.push_back(1'b1);
        if (st2) m_bits.push_back(1'b1);
    endfunction

    // One clock cycle: compare at the falling edge, advance the model at the rising edge.
    task automatic tick(input bit do_check);
        bit   hs;
        bit   pick;
        logic exp_txd;
        @(negedge clk);
        hs   = 1'b0;
        pick = 1'b0;
        if (!m_in_frame && tx_en && !rst && (req0_valid || req1_valid)) begin
            hs   = 1'b1;
            pick = (req0_valid && req1_valid) ? !m_last : req1_valid;
        end
        exp_txd = m_in_frame ? m_bits[m_pos / C] : 1'b1;
        txd_log.push_back(txd);
        if (do_check) begin
            checkOutput("txd", {31'd0, txd}, {31'd0, exp_txd});
            checkOutput("busy", {31'd0, busy}, {31'd0, m_in_frame});
            checkOutput("done", {31'd0, done}, {31'd0, m_done});
            checkOutput("grant_id", {31'd0, grant_id}, {31'd0, m_grant});
            checkOutput("req0_ready", {31'd0, req0_ready}, {31'd0, hs && !pick});
            checkOutput("req1_ready", {31'd0, req1_ready}, {31'd0, hs && pick});
            if (busy === 1'b1 && prev_busy !== 1'b1) grant_log.push_back(grant_id);
            if (done === 1'b1) done_log.push_back(cycle);
            if (busy === 1'b1) busy_cnt++;
        end
        prev_busy = busy;
        if (hs) m_hs_cycle = cycle;
        @(posedge clk);
        cycle++;
        if (rst) begin
            m_in_frame = 1'b0;
            m_done     = 1'b0;
            m_last     = 1'b1;
            m_grant    = 1'b0;
        end else if (!tx_en) begin
            m_in_frame = 1'b0;
            m_done     = 1'b0;
        end else if (m_in_frame) begin
            if (m_pos == m_bits.size() * C - 1) begin
                m_in_frame = 1'b0;
                m_done     = 1'b1;
            end else begin
                m_pos++;
                m_done = 1'b0;
            end
        end else begin
            m_done = 1'b0;
            if (hs) begin
                buildFrame(pick ? req1_data : req0_data, data_len, parity, stop_bits);
                m_in_frame = 1'b1;
                m_pos      = 0;
                m_last     = pick;
                m_grant    = pick;
            end
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b1);
    endtask

    // Each expected bit is checked on the first and last cycle of its period.
    task automatic checkFrame(input string name, input int start, input string s);
        logic e;
        for (int k = 0; k < s.len(); k++) begin
            e = (s[k] == "1");
            checkOutput($sformatf("%s_bit%0d_first", name, k),
                        {31'd0, txd_log[start + 1 + k * C]}, {31'd0, e});
            checkOutput($sformatf("%s_bit%0d_last", name, k),
                        {31'd0, txd_log[start + (k + 1) * C]}, {31'd0, e});
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 2'b00, 1'b0);
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        rst = 1'b0;
        $display("[TB] reset checked, starting directed frames");

        // 8-bit even parity, one stop bit; config scrambled after the handshake
        done_log.delete();
        applyStimulus(1'b1, 8'hAB, 1'b0, 8'h00, 1'b1, 1'b1, 2'b10, 1'b0);
        tick(1'b1);
        t0 = m_hs_cycle;
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 2'b01, 1'b1);
        run(50);
        got = (done_log.size() > 0) ? done_log[0] - t0 : -1;
        checkOutput("even8_done_latency", got, 45);
        checkFrame("even8", t0, "01101010111");

        // 7-bit odd parity, two stop bits
        done_log.delete();
        applyStimulus(1'b1, 8'h2B, 1'b0, 8'h00, 1'b1, 1'b0, 2'b01, 1'b1);
        tick(1'b1);
        t0 = m_hs_cycle;
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 2'b00, 1'b0);
        run(50);
        got = (done_log.size() > 0) ? done_log[0] - t0 : -1;
        checkOutput("odd7_done_latency", got, 45);
        checkFrame("odd7", t0, "01101010111");

        // no parity (code 11), all-ones data, two stop bits
        done_log.delete();
        busy_cnt = 0;
        applyStimulus(1'b1, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, 2'b11, 1'b1);
        tick(1'b1);
        t0 = m_hs_cycle;
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 2'b10, 1'b0);
        run(50);
        checkOutput("nopar_busy_cycles", busy_cnt, 40);
        got = (done_log.size() > 0) ? done_log[0] - t0 : -1;
        checkOutput("nopar_done_latency", got, 41);
        checkFrame("nopar", t0, "0111111111");

        // arbitration with both requesters valid continuously
        rst = 1'b1;
        tick(1'b1);
        rst = 1'b0;
        grant_log.delete();
        done_log.delete();
        applyStimulus(1'b1, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b1, 2'b00, 1'b0);
        run(170);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 2'b00, 1'b0);
        run(45);
        checkOutput("arb_grant0", {31'd0, grant_log[0]}, 0);
        checkOutput("arb_grant1", {31'd0, grant_log[1]}, 1);
        checkOutput("arb_grant2", {31'd0, grant_log[2]}, 0);
        checkOutput("arb_grant3", {31'd0, grant_log[3]}, 1);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("arb_done_gap%0d", i), done_log[i + 1] - done_log[i], 41);
        end

        // abort during DATA, then the other requester wins
        grant_log.delete();
        done_log.delete();
        applyStimulus(1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 1'b1, 2'b00, 1'b0);
        tick(1'b1);
        applyStimulus(1'b1, 8'h55, 1'b1, 8'h66, 1'b1, 1'b1, 2'b00, 1'b0);
        run(8);
        applyStimulus(1'b1, 8'h55, 1'b1, 8'h66, 1'b0, 1'b1, 2'b00, 1'b0);
        run(6);
        checkOutput("abort_no_done", done_log.size(), 0);
        applyStimulus(1'b1, 8'h55, 1'b1, 8'h66, 1'b1, 1'b1, 2'b00, 1'b0);
        run(3);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 2'b00, 1'b0);
        checkOutput("abort_frames", grant_log.size(), 2);
        checkOutput("abort_next_grant", {31'd0, grant_log[1]}, 1);
        run(50);

        // reset while a req0 frame is in STOP, then a tie goes to req0
        applyStimulus(1'b1, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b1, 2'b00, 1'b0);
        tick(1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 2'b00, 1'b0);
        run(37);
        applyStimulus(1'b1, 8'h3C, 1'b1, 8'hC3, 1'b1, 1'b1, 2'b00, 1'b0);
        rst = 1'b1;
        tick(1'b1);
        rst = 1'b0;
        grant_log.delete();
        run(3);
        checkOutput("rst_tie_grant", {31'd0, grant_log[0]}, 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 2'b00, 1'b0);
        run(45);

        // random traffic, configuration churn, aborts and resets
        $display("[TB] starting random phase");
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                          1'($urandom_range(0, 1)), 8'($urandom),
                          1'($urandom_range(0, 149) != 0), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            tick(1'b1);
        end
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 2'b00, 1'b0);
        run(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
